// File: rtl/router_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals for router_tx_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the transmitter.
interface router_tx_arbiter_if #(
  parameter int pNumReq = 4
);
  logic [pNumReq-1:0]     req_i;
  logic [128*pNumReq-1:0] dat_i;
  logic [pNumReq-1:0]     ack_o;
  logic                   tx_cs_o;
  logic                   tx_cyc_o;
  logic                   tx_stb_o;
  logic                   tx_we_o;
  logic [127:0]           tx_dat_o;
  logic                   tx_ack_i;
  logic                   tx_empty_i;
  logic                   busy_o;
  logic [2:0]             cur_o;
  logic                   err_o;

  modport master (
    input  req_i, dat_i, tx_ack_i, tx_empty_i,
    output ack_o, tx_cs_o, tx_cyc_o, tx_stb_o, tx_we_o, tx_dat_o,
           busy_o, cur_o, err_o
  );

  modport slave (
    output req_i, dat_i, tx_ack_i, tx_empty_i,
    input  ack_o, tx_cs_o, tx_cyc_o, tx_stb_o, tx_we_o, tx_dat_o,
           busy_o, cur_o, err_o
  );
endinterface

// File: rtl/router_tx_arbiter.sv
// Round-robin arbiter that shares one byte-serial router transmitter between requesters.
// Each grant issues one WISHBONE write, then waits for the transmitter's empty flag to fall and rise again.
module router_tx_arbiter #(
  parameter int pNumReq  = 4,
  parameter int pTimeout = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  router_tx_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(pTimeout + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    WAIT_LD = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  state_t             state;
  logic               empty_meta;
  logic               empty_s;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         cur;
  logic [127:0]       tx_dat;
  logic               bus_on;
  logic               busy;
  logic [pNumReq-1:0] ack;
  logic               err;

  logic               win_valid;
  logic [2:0]         win;
  int                 idx;

  // tx_empty_i comes from the transmitter's sclk domain.
  // Both flops reset to "empty", so a reset never looks like a packet being loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      empty_meta <= 1'b1;
      empty_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
      empty_meta <= bus.tx_empty_i;
      empty_s    <= empty_meta;
    end
  end

  // The search starts one past the last grant and wraps, so a lone requester can win again.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave a latch behind.
    win_valid = 1'b0;
    win       = cur;
    idx       = 0;
    for (int i = 1; i <= pNumReq; i++) begin
      idx = (int'(cur) + i) % pNumReq;
      if (!win_valid && bus.req_i[idx]) begin
        win_valid = 1'b1;
        win       = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      bus_on <= 1'b0;
      tx_dat <= '0;
      ack    <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      cur    <= 3'(pNumReq - 1);
      cnt    <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            cur    <= win;
            tx_dat <= bus.dat_i[int'(win)*128 +: 128];
            bus_on <= 1'b1;
            busy   <= 1'b1;
            state  <= WR;
          end
        end
        WR: begin
          if (bus.tx_ack_i) begin
            bus_on <= 1'b0;
            ack    <= pNumReq'(1) << cur;
            cnt    <= '0;
            state  <= WAIT_LD;
          end
        end
        WAIT_LD: begin
          if (!empty_s) begin
            state <= WAIT_TX;
          end else if (cnt == CNT_W'(pTimeout)) begin
            // The requester has already been acked, so this packet is dropped.
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_TX: begin
          if (empty_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          bus_on <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_cs_o  = bus_on;
  assign bus.tx_cyc_o = bus_on;
  assign bus.tx_stb_o = bus_on;
  assign bus.tx_we_o  = bus_on;
  assign bus.tx_dat_o = tx_dat;
  assign bus.ack_o    = ack;
  assign bus.err_o    = err;
  assign bus.busy_o   = busy;
  assign bus.cur_o    = cur;

endmodule
